apb_arbiter: RTL and testbench
==============================

Name: apb_arbiter

Overview:
- N-to-1 APB arbiter. It shares one downstream APB slave path (delayer, then the peripheral crossbar) between several APB masters, e.g. IFU and LSU.
- It grants one master per transfer and regenerates clean SETUP/ACCESS phases toward the slave.
- It routes the response back to the granted master only.
- It inserts one idle bus cycle between transfers, so downstream blocks see PSEL/PENABLE deassert before the next transfer.

Parameters:
- NUM_M, 2, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width. Strobe width is DW/8.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m_paddr  in  NUM_M*AW  per-master address; master i occupies slice [i*AW +: AW].
- m_psel  in  NUM_M  per-master select; this is the request.
- m_penable  in  NUM_M  per-master enable; protocol only, not used for arbitration.
- m_pprot  in  NUM_M*3  per-master protection.
- m_pwrite  in  NUM_M  per-master write flag.
- m_pwdata  in  NUM_M*DW  per-master write data.
- m_pstrb  in  NUM_M*(DW/8)  per-master byte strobes.
- m_pready  out  NUM_M  per-master ready; only the granted bit can be 1.
- m_prdata  out  DW  read data, shared by all masters; valid with the m_pready bit.
- m_pslverr  out  NUM_M  per-master error; qualified by m_pready.
- s_paddr, s_pprot, s_pwrite, s_pwdata, s_pstrb  out  AW/3/1/DW/DW/8  slave request fields, taken from the granted master.
- s_psel  out  1  slave select.
- s_penable  out  1  slave enable.
- s_pready  in  1  slave ready.
- s_prdata  in  DW  slave read data.
- s_pslverr  in  1  slave error.

Behaviour:
- States:
  - IDLE: s_psel=0, s_penable=0.
  - SETUP: s_psel=1, s_penable=0. Lasts exactly 1 cycle.
  - ACCESS: s_psel=1, s_penable=1.
  - DONE: 1 cycle, s_psel=0.
- Transitions:
  - IDLE -> SETUP when any m_psel bit is 1. grant is registered that cycle.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> DONE on s_pready=1; otherwise stay in ACCESS.
  - DONE -> IDLE.
- Slave fields: s_* request fields are a registered copy of the granted master's fields, captured at grant. Masters must hold their fields stable while m_psel is high.
- Response path: in the ACCESS cycle where s_pready=1, the arbiter registers m_pready[grant]=1, m_prdata=s_prdata, and m_pslverr[grant]=s_pslverr. The master therefore sees its pready in the DONE cycle, one cycle after the slave's pready, and for exactly 1 cycle.
- Latency: minimum 4 cycles from the first cycle m_psel is seen to m_pready, if the slave is ready in its first ACCESS cycle.
- Arbitration: round-robin.
  - A last pointer is updated at each grant.
  - The search starts at last+1, wrapping modulo NUM_M.
  - A master that drops m_psel before being granted is simply not selected; there is no error.
- Non-granted masters: see m_pready=0 and m_pslverr=0 and wait indefinitely.
- Back-to-back requests: a master re-requesting in DONE cannot be granted before IDLE. The minimum gap between slave transfers is 2 cycles (DONE, IDLE) with psel low.
- Simultaneous requests: all masters requesting in the same cycle are served in round-robin order, one transfer each.
- Reset:
  - state=IDLE, grant=0, last=NUM_M-1, so master 0 wins first.
  - All s_* outputs 0, m_pready=0, m_prdata=0, m_pslverr=0.
  - Reset mid-transfer aborts with no response. The slave sees psel drop immediately.
- Grant width: $clog2(NUM_M); NUM_M=1 is illegal.

Optional Feature:
- APB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins and last is unused. Starvation of high indices is accepted.
- Undefined: round-robin as above.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS, DONE) and the APB phase encodings.
- One sub-module: apb_rr_pick. It is combinational: inputs req[NUM_M] and last, outputs a one-hot/indexed winner plus a valid flag. The fixed-priority variant is selected inside it by the macro.

Test Plan:
- Single master: m_psel[0]=1, write addr 0x1000_0000, data 0xDEADBEEF, strb 0xF; slave ready on the 3rd ACCESS cycle -> s_* match, s_penable rises one cycle after s_psel, m_pready[0] is a 1-cycle pulse one cycle after s_pready, m_pready[1] stays 0.
- Simultaneous requests: m_psel=2'b11 from reset -> master 0 served, then master 1. s_psel is low 2 cycles between transfers. With both held, grants alternate 0,1,0,1.
- Read path: master 1 reads, s_prdata=0x12345678, s_pslverr=1 -> m_prdata=0x12345678, m_pslverr[1]=1, m_pslverr[0]=0.
- Request withdrawal: master 1 raises m_psel for 1 cycle during master 0's ACCESS, then drops it -> master 1 is never granted and the arbiter returns to IDLE.
- Reset mid-ACCESS: assert reset while s_pready=0 -> all outputs 0 asynchronously. After release, a pending m_psel[1] gets a fresh SETUP.
- With APB_ARB_FIXED_PRIO_EN: both masters hold requests -> master 0 is granted every transfer and master 1 is starved.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB arbiter: FSM state enum and APB bus phase encodings.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic psel;
    logic penable;
  } apb_phase_t;

  localparam apb_phase_t PHASE_IDLE   = '{psel: 1'b0, penable: 1'b0};
  localparam apb_phase_t PHASE_SETUP  = '{psel: 1'b1, penable: 1'b0};
  localparam apb_phase_t PHASE_ACCESS = '{psel: 1'b1, penable: 1'b1};

  // Downstream PSEL/PENABLE pair driven while the arbiter sits in a given state.
  function automatic apb_phase_t phase_of(input arb_state_e st);
    apb_phase_t ph;
    ph = PHASE_IDLE;
    case (st)
      ST_SETUP:  ph = PHASE_SETUP;
      ST_ACCESS: ph = PHASE_ACCESS;
      default:   ph = PHASE_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// Bundle of the N upstream APB master ports and the single downstream APB slave port.
// Modport slave is the arbiter's view; modport master is the surrounding system's view.
interface apb_arbiter_if #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned SW = DW / 8;

  logic [NUM_M*AW-1:0] m_paddr;
  logic [NUM_M-1:0]    m_psel;
  logic [NUM_M-1:0]    m_penable;
  logic [NUM_M*3-1:0]  m_pprot;
  logic [NUM_M-1:0]    m_pwrite;
  logic [NUM_M*DW-1:0] m_pwdata;
  logic [NUM_M*SW-1:0] m_pstrb;
  logic [NUM_M-1:0]    m_pready;
  logic [DW-1:0]       m_prdata;
  logic [NUM_M-1:0]    m_pslverr;

  logic [AW-1:0]       s_paddr;
  logic [2:0]          s_pprot;
  logic                s_pwrite;
  logic [DW-1:0]       s_pwdata;
  logic [SW-1:0]       s_pstrb;
  logic                s_psel;
  logic                s_penable;
  logic                s_pready;
  logic [DW-1:0]       s_prdata;
  logic                s_pslverr;

  modport slave (
    input  m_paddr, m_psel, m_penable, m_pprot, m_pwrite, m_pwdata, m_pstrb,
    output m_pready, m_prdata, m_pslverr,
    output s_paddr, s_pprot, s_pwrite, s_pwdata, s_pstrb, s_psel, s_penable,
    input  s_pready, s_prdata, s_pslverr
  );

  modport master (
    output m_paddr, m_psel, m_penable, m_pprot, m_pwrite, m_pwdata, m_pstrb,
    input  m_pready, m_prdata, m_pslverr,
    input  s_paddr, s_pprot, s_pwrite, s_pwdata, s_pstrb, s_psel, s_penable,
    output s_pready, s_prdata, s_pslverr
  );

endinterface

// File: rtl/apb_rr_pick.sv
// Combinational winner selection among requesting masters: round-robin after `last`,
// or fixed lowest-index priority when APB_ARB_FIXED_PRIO_EN is defined.
module apb_rr_pick #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned GW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [NUM_M-1:0] grant_oh_c,
  output logic [GW-1:0]    grant_idx_c,
  output logic             valid_c
);

`ifdef APB_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    valid_c     = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!valid_c && req[i]) begin
        grant_oh_c[i] = 1'b1;
        grant_idx_c   = GW'(i);
        valid_c       = 1'b1;
      end
    end
  end
`else
  // Two passes give the rotated search: indices above `last` first, then wrap to 0.
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    valid_c     = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!valid_c && req[i] && (GW'(i) > last)) begin
        grant_oh_c[i] = 1'b1;
        grant_idx_c   = GW'(i);
        valid_c       = 1'b1;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!valid_c && req[i]) begin
        grant_oh_c[i] = 1'b1;
        grant_idx_c   = GW'(i);
        valid_c       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/apb_arbiter.sv
// N-to-1 APB arbiter: grants one master per transfer, regenerates SETUP/ACCESS toward the
// slave and inserts an idle cycle after each transfer. Macro: APB_ARB_FIXED_PRIO_EN.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  apb_arbiter_if.slave  bus
);

  localparam int unsigned GW = $clog2(NUM_M);
  localparam int unsigned SW = DW / 8;

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    last_q;
  logic             grant_fire;
  logic             resp_fire;
  apb_phase_t       phase_d;

  logic [NUM_M-1:0] pick_oh_c;
  logic [GW-1:0]    pick_idx_c;
  logic             pick_valid_c;

  logic [AW-1:0]    sel_paddr;
  logic [2:0]       sel_pprot;
  logic             sel_pwrite;
  logic [DW-1:0]    sel_pwdata;
  logic [SW-1:0]    sel_pstrb;

  logic [NUM_M-1:0] pready_d;
  logic [NUM_M-1:0] pslverr_d;

  // Upstream PENABLE only matters to the masters' own protocol, not to arbitration.
  logic unused_penable;
  assign unused_penable = ^bus.m_penable;

  apb_rr_pick #(
    .NUM_M (NUM_M),
    .GW    (GW)
  ) u_pick (
    .req         (bus.m_psel),
    .last        (last_q),
    .grant_oh_c  (pick_oh_c),
    .grant_idx_c (pick_idx_c),
    .valid_c     (pick_valid_c)
  );

  // Request fields of the winning master, muxed by the one-hot pick.
  always_comb begin
    sel_paddr  = '0;
    sel_pprot  = '0;
    sel_pwrite = 1'b0;
    sel_pwdata = '0;
    sel_pstrb  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_oh_c[i]) begin
        sel_paddr  = bus.m_paddr[i*AW +: AW];
        sel_pprot  = bus.m_pprot[i*3 +: 3];
        sel_pwrite = bus.m_pwrite[i];
        sel_pwdata = bus.m_pwdata[i*DW +: DW];
        sel_pstrb  = bus.m_pstrb[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    resp_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          grant_fire = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.s_pready) begin
          resp_fire = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    phase_d = phase_of(state_d);
  end

  // Response is steered to the granted master only; everyone else sees zeros.
  always_comb begin
    pready_d  = '0;
    pslverr_d = '0;
    for (int i = 0; i < NUM_M; i++) begin
      pready_d[i]  = resp_fire && (grant_q == GW'(i));
      pslverr_d[i] = pready_d[i] && bus.s_pslverr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q       <= '0;
      last_q        <= GW'(NUM_M - 1);
      bus.s_psel    <= 1'b0;
      bus.s_penable <= 1'b0;
      bus.s_paddr   <= '0;
      bus.s_pprot   <= '0;
      bus.s_pwrite  <= 1'b0;
      bus.s_pwdata  <= '0;
      bus.s_pstrb   <= '0;
      bus.m_pready  <= '0;
      bus.m_pslverr <= '0;
      bus.m_prdata  <= '0;
    end else begin
      bus.s_psel    <= phase_d.psel;
      bus.s_penable <= phase_d.penable;
      bus.m_pready  <= pready_d;
      bus.m_pslverr <= pslverr_d;
      if (grant_fire) begin
        grant_q      <= pick_idx_c;
        last_q       <= pick_idx_c;
        bus.s_paddr  <= sel_paddr;
        bus.s_pprot  <= sel_pprot;
        bus.s_pwrite <= sel_pwrite;
        bus.s_pwdata <= sel_pwdata;
        bus.s_pstrb  <= sel_pstrb;
      end
      if (resp_fire) begin
        bus.m_prdata <= bus.s_prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level model of the arbiter.
module tb_apb_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  apb_arbiter_if #(.NUM_M(N), .AW(AW), .DW(DW)) bus ();

  apb_arbiter #(.NUM_M(N), .AW(AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int            cyc       = 0;
  int            owner     = -1;
  int            last_m    = N - 1;
  int            grant_cyc = 0;
  int            free_at   = 0;
  logic          e_psel    = 1'b0;
  logic          e_penable = 1'b0;
  logic [AW-1:0] e_paddr   = '0;
  logic [2:0]    e_pprot   = '0;
  logic          e_pwrite  = 1'b0;
  logic [DW-1:0] e_pwdata  = '0;
  logic [SW-1:0] e_pstrb   = '0;
  logic [N-1:0]  e_pready  = '0;
  logic [N-1:0]  e_pslverr = '0;
  logic [DW-1:0] e_prdata  = '0;

  function automatic int pick(input logic [N-1:0] req, input int last);
`ifdef APB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < int'(N); i++) if (req[i]) return i;
`else
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (last + k) % int'(N);
      if (req[c]) return c;
    end
`endif
    return -1;
  endfunction

  // A transfer granted at cycle g drives SETUP in g+1, can complete from g+2 onward,
  // and the next grant is possible two cycles after completion.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      owner = -1; last_m = N - 1; free_at = 0;
      e_psel = 0; e_penable = 0; e_paddr = '0; e_pprot = '0; e_pwrite = 0;
      e_pwdata = '0; e_pstrb = '0; e_pready = '0; e_pslverr = '0; e_prdata = '0;
    end else begin
      cyc++;
      e_pready  = '0;
      e_pslverr = '0;
      if (owner >= 0) begin
        if (cyc >= grant_cyc + 2 && bus.s_pready) begin
          e_pready[owner]  = 1'b1;
          e_pslverr[owner] = bus.s_pslverr;
          e_prdata         = bus.s_prdata;
          owner            = -1;
          free_at          = cyc + 2;
        end
      end else if (cyc >= free_at && (|bus.m_psel)) begin
        owner     = pick(bus.m_psel, last_m);
        last_m    = owner;
        grant_cyc = cyc;
        e_paddr   = bus.m_paddr[owner*AW +: AW];
        e_pprot   = bus.m_pprot[owner*3 +: 3];
        e_pwrite  = bus.m_pwrite[owner];
        e_pwdata  = bus.m_pwdata[owner*DW +: DW];
        e_pstrb   = bus.m_pstrb[owner*SW +: SW];
      end
      e_psel    = (owner >= 0);
      e_penable = (owner >= 0) && (cyc >= grant_cyc + 1);
    end
  end

  always @(negedge clock) begin
    check("s_psel",    64'(bus.s_psel),    64'(e_psel));
    check("s_penable", 64'(bus.s_penable), 64'(e_penable));
    check("s_paddr",   64'(bus.s_paddr),   64'(e_paddr));
    check("s_pprot",   64'(bus.s_pprot),   64'(e_pprot));
    check("s_pwrite",  64'(bus.s_pwrite),  64'(e_pwrite));
    check("s_pwdata",  64'(bus.s_pwdata),  64'(e_pwdata));
    check("s_pstrb",   64'(bus.s_pstrb),   64'(e_pstrb));
    check("m_pready",  64'(bus.m_pready),  64'(e_pready));
    check("m_pslverr", 64'(bus.m_pslverr), 64'(e_pslverr));
    check("m_prdata",  64'(bus.m_prdata),  64'(e_prdata));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_master(input int i, input logic sel, input logic [AW-1:0] addr,
                            input logic wr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] strb, input logic [2:0] prot);
    bus.m_psel[i]               = sel;
    bus.m_penable[i]            = sel;
    bus.m_paddr[i*AW +: AW]     = addr;
    bus.m_pwrite[i]             = wr;
    bus.m_pwdata[i*DW +: DW]    = wdata;
    bus.m_pstrb[i*SW +: SW]     = strb;
    bus.m_pprot[i*3 +: 3]       = prot;
  endtask

  task automatic drop_master(input int i);
    bus.m_psel[i]    = 1'b0;
    bus.m_penable[i] = 1'b0;
  endtask

  int g_seq [4];
  int gap_seq [4];

  initial begin
    bus.m_paddr = '0; bus.m_psel = '0; bus.m_penable = '0; bus.m_pprot = '0;
    bus.m_pwrite = '0; bus.m_pwdata = '0; bus.m_pstrb = '0;
    bus.s_pready = 1'b0; bus.s_prdata = '0; bus.s_pslverr = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_s_psel",   64'(bus.s_psel),   64'h0);
    check("rst_m_pready", 64'(bus.m_pready), 64'h0);
    check("rst_m_prdata", 64'(bus.m_prdata), 64'h0);
    check("rst_s_paddr",  64'(bus.s_paddr),  64'h0);
    reset = 1'b0;
    tick();

    // Single master write, slave ready on the third ACCESS cycle.
    set_master(0, 1'b1, 32'h1000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
    tick();
    check("wr_setup_psel",    64'(bus.s_psel),    64'h1);
    check("wr_setup_penable", 64'(bus.s_penable), 64'h0);
    check("wr_paddr",         64'(bus.s_paddr),   64'h1000_0000);
    check("wr_pwdata",        64'(bus.s_pwdata),  64'hDEAD_BEEF);
    check("wr_pstrb",         64'(bus.s_pstrb),   64'hF);
    check("wr_pwrite",        64'(bus.s_pwrite),  64'h1);
    tick();
    check("wr_access_penable", 64'(bus.s_penable), 64'h1);
    tick();
    tick();
    bus.s_pready = 1'b1;
    check("wr_no_early_pready", 64'(bus.m_pready), 64'h0);
    tick();
    check("wr_done_pready", 64'(bus.m_pready), 64'h1);
    check("wr_done_psel",   64'(bus.s_psel),   64'h0);
    drop_master(0);
    bus.s_pready = 1'b0;
    tick();
    check("wr_pready_pulse", 64'(bus.m_pready), 64'h0);
    tick();

    // Read with error from master 1.
    set_master(1, 1'b1, 32'h2000_0040, 1'b0, '0, '0, 3'b010);
    bus.s_pready = 1'b1; bus.s_prdata = 32'h1234_5678; bus.s_pslverr = 1'b1;
    tick();
    check("rd_paddr", 64'(bus.s_paddr), 64'h2000_0040);
    tick();
    tick();
    check("rd_prdata",  64'(bus.m_prdata),  64'h1234_5678);
    check("rd_pslverr", 64'(bus.m_pslverr), 64'h2);
    check("rd_pready",  64'(bus.m_pready),  64'h2);
    drop_master(1);
    bus.s_pready = 1'b0; bus.s_pslverr = 1'b0;
    repeat (2) tick();

    // Simultaneous requests from reset, both held.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_master(0, 1'b1, 32'hA000_0000, 1'b1, 32'h0000_00AA, 4'h3, 3'b001);
    set_master(1, 1'b1, 32'hB000_0004, 1'b1, 32'h0000_00BB, 4'hC, 3'b100);
    bus.s_pready = 1'b1;
    begin
      int ng, gap;
      ng = 0; gap = 0;
      for (int c = 0; c < 60 && ng < 4; c++) begin
        tick();
        if (bus.s_psel && !bus.s_penable) begin
          g_seq[ng]   = (bus.s_paddr == 32'hA000_0000) ? 0 :
                        (bus.s_paddr == 32'hB000_0004) ? 1 : 9;
          gap_seq[ng] = gap;
          gap = 0;
          ng++;
        end else if (!bus.s_psel) begin
          gap++;
        end
      end
      check("sim_grant_count", 64'(ng), 64'd4);
`ifdef APB_ARB_FIXED_PRIO_EN
      check("sim_g0", 64'(g_seq[0]), 64'd0);
      check("sim_g1", 64'(g_seq[1]), 64'd0);
      check("sim_g2", 64'(g_seq[2]), 64'd0);
      check("sim_g3", 64'(g_seq[3]), 64'd0);
`else
      check("sim_g0", 64'(g_seq[0]), 64'd0);
      check("sim_g1", 64'(g_seq[1]), 64'd1);
      check("sim_g2", 64'(g_seq[2]), 64'd0);
      check("sim_g3", 64'(g_seq[3]), 64'd1);
`endif
      check("sim_gap1", 64'(gap_seq[1]), 64'd2);
      check("sim_gap3", 64'(gap_seq[3]), 64'd2);
    end
    drop_master(0);
    drop_master(1);
    repeat (4) tick();

    // Master 1 raises and withdraws its request during master 0's ACCESS.
    bus.s_pready = 1'b0;
    set_master(0, 1'b1, 32'h0000_1000, 1'b1, 32'h5555_AAAA, 4'hF, 3'b000);
    tick();
    tick();
    set_master(1, 1'b1, 32'h0000_2000, 1'b0, '0, '0, 3'b000);
    tick();
    drop_master(1);
    tick();
    bus.s_pready = 1'b1;
    tick();
    check("wd_m0_pready", 64'(bus.m_pready), 64'h1);
    drop_master(0);
    bus.s_pready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("wd_stays_idle", 64'(bus.s_psel), 64'h0);
    end

    // Reset in the middle of an ACCESS phase, request from master 1 still pending.
    set_master(1, 1'b1, 32'h3000_0008, 1'b1, 32'hCAFE_F00D, 4'h5, 3'b011);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_psel",    64'(bus.s_psel),    64'h0);
    check("rst_mid_penable", 64'(bus.s_penable), 64'h0);
    check("rst_mid_paddr",   64'(bus.s_paddr),   64'h0);
    check("rst_mid_pready",  64'(bus.m_pready),  64'h0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_fresh_psel",    64'(bus.s_psel),    64'h1);
    check("rst_fresh_penable", 64'(bus.s_penable), 64'h0);
    check("rst_fresh_paddr",   64'(bus.s_paddr),   64'h3000_0008);
    tick();
    bus.s_pready = 1'b1;
    tick();
    check("rst_fresh_pready", 64'(bus.m_pready), 64'h2);
    drop_master(1);
    bus.s_pready = 1'b0;
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.s_pready  = ($urandom_range(99) < 40);
      bus.s_prdata  = $urandom;
      bus.s_pslverr = ($urandom_range(3) == 0);
      for (int i = 0; i < int'(N); i++) begin
        if (bus.m_pready[i]) begin
          if ($urandom_range(1) == 0) drop_master(i);
          else set_master(i, 1'b1, $urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
        end else if (!bus.m_psel[i]) begin
          if ($urandom_range(99) < 30)
            set_master(i, 1'b1, $urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
        end else if (i != owner && $urandom_range(99) < 5) begin
          drop_master(i);
        end
      end
    end
    bus.m_psel = '0;
    bus.m_penable = '0;
    bus.s_pready = 1'b1;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
